// File: rtl/muxn_rr_reg.sv
// muxn_rr_reg
//   Selects one of NUM_CH = 2**SEL_W source channels and registers the chosen
//   word into a one-entry output stage with valid/ready handshaking. The
//   channel is chosen either by a fixed select code (mode 0) or by a
//   round-robin arbiter over all requesting channels (mode 1).
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_data    packed channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel request
//   in_ready   per-channel accept (one-hot or zero)
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in mode 0
//   out_data   registered selected data
//   out_ch     index of the channel that produced out_data
//   out_valid  output register holds valid data
//   out_ready  downstream accept
module muxn_rr_reg #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [(2**SEL_W)*WIDTH-1:0] in_data,
  input  logic [(2**SEL_W)-1:0]       in_valid,
  output logic [(2**SEL_W)-1:0]       in_ready,
  input  logic                        mode,
  input  logic [SEL_W-1:0]            sel,
  output logic [WIDTH-1:0]            out_data,
  output logic [SEL_W-1:0]            out_ch,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int NUM_CH = 2**SEL_W;

  // Round-robin search: first requester at or after start, wrapping.
  // Returns {found, index}. The index add wraps naturally at SEL_W bits.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                             input logic [SEL_W-1:0]  start);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = start + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  logic [WIDTH-1:0] chan [NUM_CH];
  logic [SEL_W-1:0] ptr;
  logic             gvld_p0;
  logic [SEL_W-1:0] gidx_p0;
  logic             load_en_p0;
  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] ch_p1;
  logic             vld_p1;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      chan[k] = in_data[k*WIDTH +: WIDTH];
    end
  end

  // ---- p0: grant and accept (combinational) ----
  always_comb begin
    gvld_p0 = 1'b0;
    gidx_p0 = '0;
    if (!mode) begin
      gvld_p0 = in_valid[sel];
      gidx_p0 = sel;
    end else begin
      {gvld_p0, gidx_p0} = rr_pick(in_valid, ptr);
    end
  end

  // Empty or draining this cycle: a new word may replace the held one.
  assign load_en_p0 = ~vld_p1 | out_ready;

  always_comb begin
    in_ready = '0;
    if (rst_n && load_en_p0 && gvld_p0) begin
      in_ready[gidx_p0] = 1'b1;
    end
  end

  // ---- p1: output register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      ptr     <= '0;
    end else if (load_en_p0) begin
      if (gvld_p0) begin
        data_p1 <= chan[gidx_p0];
        ch_p1   <= gidx_p0;
        vld_p1  <= 1'b1;
        // Only the arbiter advances the pointer; fixed select leaves it alone.
        if (mode) begin
          ptr <= gidx_p0 + 1'b1;
        end
      end else begin
        // Drained with nothing to replace it; data/channel keep last value.
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_ch    = ch_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_muxn_rr_reg.sv
module tb_muxn_rr_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dat [4];
  logic [127:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  // Reference model of the output stage.
  logic        m_vld;
  logic [31:0] m_data;
  int          m_ch;
  int          m_ptr;

  assign in_data = {dat[3], dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  muxn_rr_reg #(.WIDTH(32), .SEL_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Channel that would be granted now, or -1.
  function automatic int exp_grant();
    int c;
    if (!mode) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < 4; k++) begin
      c = (m_ptr + k) % 4;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    int g;
    r = 4'b0000;
    if (rst_n && (!m_vld || out_ready)) begin
      g = exp_grant();
      if (g >= 0) r[g] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_edge();
    int g;
    if (!rst_n) begin
      m_vld = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
    end else if (!m_vld || out_ready) begin
      g = exp_grant();
      if (g >= 0) begin
        m_data = dat[g];
        m_ch   = g;
        m_vld  = 1'b1;
        if (mode) m_ptr = (g + 1) % 4;
      end else begin
        m_vld = 1'b0;
      end
    end
  endtask

  // Advance one clock edge, update the model, then settle past the edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'hF; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) dat[k] = 32'h1000_0000 + k;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
    cycle();
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++;
    if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch got %0d exp 0", out_ch); end
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_hold_in_ready got %b exp 0000", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", in_ready); end
    cycle();
    checks++;
    if (out_ch !== 2'd0 || out_data !== 32'h1000_0000) begin
      errors++; $display("FAIL reset_first_word got ch %0d data %h exp ch 0 data 10000000", out_ch, out_data);
    end
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    dat[2] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_in_ready got %b exp 0100", in_ready); end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_ch !== 2'd2) begin
      errors++; $display("FAIL fixed_out got v %b data %h ch %0d exp v 1 data deadbeef ch 2", out_valid, out_data, out_ch);
    end
    in_valid = 4'b1011;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_nogrant_ready got %b exp 0000", in_ready); end
    cycle();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL fixed_nogrant_out got v %b data %h exp v 0 data deadbeef", out_valid, out_data);
    end
  endtask

  task automatic test_rr_fairness();
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) dat[k] = $urandom;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'(seq[i]) || out_data !== dat[seq[i]]) begin
        errors++;
        $display("FAIL rr_seq[%0d] got v %b ch %0d data %h exp v 1 ch %0d data %h",
                 i, out_valid, out_ch, out_data, seq[i], dat[seq[i]]);
      end
    end
  endtask

  task automatic test_wrap();
    // Pointer is 2 after the fairness run; a ch2 grant moves it to 3.
    mode = 1'b1; out_ready = 1'b1;
    in_valid = 4'b0100;
    cycle();
    in_valid = 4'b0010;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin errors++; $display("FAIL wrap_grant_ch1 got %b exp 0010", in_ready); end
    cycle();
    checks++;
    if (out_ch !== 2'd1) begin errors++; $display("FAIL wrap_out_ch got %0d exp 1", out_ch); end
    in_valid = 4'b1110;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ptr2 got %b exp 0100", in_ready); end
    in_valid = 4'b1000;
    cycle();
    in_valid = 4'b1011;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_after_ch3 got %b exp 0001", in_ready); end
    cycle();
  endtask

  task automatic test_backpressure();
    logic [31:0] held_d;
    logic [1:0]  held_c;
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1000; dat[3] = 32'hCAFE_0003;
    cycle();
    held_d = 32'hCAFE_0003; held_c = 2'd3;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 4'($urandom); mode = 1'($urandom); sel = 2'($urandom);
      for (int k = 0; k < 4; k++) dat[k] = $urandom;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0000", i, in_ready); end
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== held_d || out_ch !== held_c) begin
        errors++; $display("FAIL bp_hold[%0d] got v %b data %h ch %0d exp v 1 data %h ch %0d",
                           i, out_valid, out_data, out_ch, held_d, held_c);
      end
    end
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; dat[2] = 32'h5555_AAAA; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b exp 0100", in_ready); end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h5555_AAAA || out_ch !== 2'd2) begin
      errors++; $display("FAIL bp_release_out got v %b data %h ch %0d exp v 1 data 5555aaaa ch 2", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_reset_mid();
    // Grant ch2 in round-robin so the pointer is non-zero, then stall.
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0100;
    cycle();
    out_ready = 1'b0; in_valid = 4'hF;
    cycle();
    rst_n = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++; $display("FAIL midreset_out got v %b data %h exp v 0 data 0", out_valid, out_data);
    end
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL midreset_ptr got %b exp 0001", in_ready); end
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) dat[k] = $urandom;
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        errors++; $display("FAIL rand_ready[%0d] got %b exp %b", i, in_ready, exp_ready());
      end
      cycle();
      checks++;
      if (out_valid !== m_vld || out_ch !== 2'(m_ch) || out_data !== m_data) begin
        errors++;
        $display("FAIL rand_out[%0d] got v %b ch %0d data %h exp v %b ch %0d data %h",
                 i, out_valid, out_ch, out_data, m_vld, m_ch, m_data);
      end
    end
  endtask

  initial begin
    m_vld = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
    rst_n = 1'b0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) dat[k] = '0;
    #1;
    test_reset();
    test_fixed();
    test_rr_fairness();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
